// File: rtl/oh_simstimulus_if.sv
// oh_simstimulus_if: valid/ready packet handshake between stimulus source and DUT
interface oh_simstimulus_if #(parameter int DW = 32);
  logic valid;
  logic ready;
  logic [DW-1:0] packet;
  modport master (output valid, output packet, input ready);
  modport slave (input valid, input packet, output ready);
endinterface

// File: rtl/oh_simstimulus.sv
// oh_simstimulus: replays a {gap,data} table as packets over valid/ready with per-entry idle gaps
module oh_simstimulus #(
  parameter int DW = 32,
  parameter int MAW = 10,
  parameter int GW = 16,
  parameter FILENAME = "NONE"
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                go,
  input  logic [MAW:0]        num_entries,
  input  logic                mem_we,
  input  logic [MAW-1:0]      mem_addr,
  input  logic [GW+DW-1:0]    mem_wdata,
  oh_simstimulus_if.master    stim,
  output logic [MAW:0]        stim_count,
  output logic                stim_done
);
  localparam int MW = GW + DW;
  localparam logic [MAW:0] MAXN = {1'b1, {MAW{1'b0}}};
  typedef enum logic [1:0] {IDLE, GAP, SEND, DONE} state_t;
  state_t state, state_nxt;
  logic [MW-1:0] mem [2**MAW];
  logic [MAW:0] n, n_in;
  logic [MAW-1:0] addr, addr_nxt, addr_sel;
  logic [GW-1:0] cnt, gap0, gapn;
  logic hs, last;
  assign n_in = num_entries > MAXN ? MAXN : num_entries;
  assign addr_nxt = addr + 1'b1;
  assign gap0 = mem[0][MW-1:DW];
  assign gapn = mem[addr_nxt][MW-1:DW];
  assign hs = state == SEND && stim.ready;
  assign last = stim_count + 1'b1 == n;
  assign addr_sel = hs ? addr_nxt : state == IDLE ? '0 : addr;
  assign stim.valid = state == SEND;
  assign stim_done = state == DONE;
  always_ff @(posedge clk)
    if (mem_we && (state == IDLE || state == DONE)) mem[mem_addr] <= mem_wdata;
`ifdef CFG_SIM
  always_ff @(posedge clk)
    if (mem_we && (state == GAP || state == SEND))
      $display("ERROR: oh_simstimulus table write ignored while sending, addr=%0h", mem_addr);
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (go) state_nxt = n_in == '0 ? DONE : gap0 != '0 ? GAP : SEND;
      GAP:  if (cnt == GW'(1)) state_nxt = SEND;
      SEND: if (hs) state_nxt = last ? DONE : gapn != '0 ? GAP : SEND;
      DONE: if (!go) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state <= IDLE;
      n <= '0;
      addr <= '0;
      cnt <= '0;
      stim_count <= '0;
      stim.packet <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && go) begin
        n <= n_in;
        addr <= '0;
        stim_count <= '0;
        cnt <= gap0;
      end
      if (state == GAP) cnt <= cnt - 1'b1;
      if (hs) begin
        stim_count <= stim_count + 1'b1;
        addr <= addr_nxt;
        cnt <= gapn;
      end
      if (state_nxt == SEND) stim.packet <= mem[addr_sel][DW-1:0];
    end
endmodule

// File: tb/tb_oh_simstimulus.sv
// tb_oh_simstimulus: directed and random replay runs checked against a
// table-level model of the expected packet/gap sequence
module tb_oh_simstimulus;
  localparam int DW = 16, MAW = 2, GW = 4, MW = GW + DW, DEPTH = 4;
  logic clk = 0, nreset = 0, go = 0, mem_we = 0;
  logic [MAW:0] num_entries = '0;
  logic [MAW-1:0] mem_addr = '0;
  logic [MW-1:0] mem_wdata = '0;
  logic [MAW:0] stim_count;
  logic stim_done;
  int vectors = 0, errors = 0;
  logic [GW-1:0] gap_m [DEPTH];
  logic [DW-1:0] dat_m [DEPTH];
  oh_simstimulus_if #(.DW(DW)) bus ();
  oh_simstimulus #(.DW(DW), .MAW(MAW), .GW(GW)) dut (
    .clk(clk), .nreset(nreset), .go(go), .num_entries(num_entries),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stim(bus.master), .stim_count(stim_count), .stim_done(stim_done));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic load(input int a, input logic [GW-1:0] g, input logic [DW-1:0] d);
    @(negedge clk);
    mem_we = 1; mem_addr = MAW'(a); mem_wdata = {g, d};
    gap_m[a] = g; dat_m[a] = d;
    @(negedge clk);
    mem_we = 0;
  endtask
  // mode 0: always ready, 1: random ready, 2: stall packet 1 for 4 cycles
  task automatic run(input int n, input int mode, input bit poke);
    int m, t, stall;
    bit rdy;
    m = n > DEPTH ? DEPTH : n;
    stall = 0;
    @(negedge clk);
    num_entries = (MAW+1)'(n); go = 1; bus.ready = 0;
    for (int i = 0; i < m; i++) begin
      for (int g = 0; g < int'(gap_m[i % DEPTH]); g++) begin
        @(negedge clk);
        mem_we = 0;
        chk("gap_valid", bus.valid, 0);
      end
      t = 0;
      do begin
        @(negedge clk);
        chk("valid", bus.valid, 1);
        chk("packet", bus.packet, dat_m[i % DEPTH]);
        chk("count", stim_count, i);
        if (poke && i == 0 && t == 0) begin
          mem_we = 1; mem_addr = 1; mem_wdata = MW'($urandom);
        end else mem_we = 0;
        rdy = mode == 0 ? 1'b1 : mode == 2 ? !(i == 1 && stall < 4) : 1'($urandom);
        if (!rdy) stall++;
        bus.ready = rdy;
        t++;
      end while (!rdy && t < 60);
      if (!rdy) begin
        chk("handshake_timeout", 0, 1);
        break;
      end
    end
    @(negedge clk);
    mem_we = 0; bus.ready = 0;
    chk("done", stim_done, 1);
    chk("done_valid", bus.valid, 0);
    chk("done_count", stim_count, m);
    if (m > 0) chk("done_packet", bus.packet, dat_m[(m-1) % DEPTH]);
    @(negedge clk);
    chk("done_hold", stim_done, 1);
    chk("done_hold_valid", bus.valid, 0);
    go = 0;
    @(negedge clk);
    chk("idle_done", stim_done, 0);
  endtask
  initial begin
    bus.ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.valid, 0);
    chk("rst_done", stim_done, 0);
    chk("rst_count", stim_count, 0);
    chk("rst_packet", bus.packet, 0);
    nreset = 1;
    load(0, 0, 16'hA0A0); load(1, 0, 16'hA1A1); load(2, 0, 16'hA2A2); load(3, 0, 16'hA3A3);
    run(3, 0, 0);
    load(1, 2, 16'hA1A1);
    run(3, 0, 0);
    load(0, 3, 16'hA0A0);
    run(3, 0, 0);
    load(0, 0, 16'hB0B0); load(1, 0, 16'hB1B1);
    run(3, 2, 0);
    run(0, 0, 0);
    run(4, 0, 1);
    run(7, 1, 0);
    repeat (8) begin
      for (int a = 0; a < DEPTH; a++) load(a, GW'($urandom_range(0, 3)), DW'($urandom));
      run($urandom_range(0, 7), 1, 0);
    end
    load(0, 0, 16'hC0C0); load(1, 1, 16'hC1C1); load(2, 0, 16'hC2C2);
    @(negedge clk);
    num_entries = 3; go = 1; bus.ready = 0;
    repeat (2) @(negedge clk);
    #2 nreset = 0;
    #1;
    chk("midrst_valid", bus.valid, 0);
    chk("midrst_done", stim_done, 0);
    chk("midrst_count", stim_count, 0);
    chk("midrst_packet", bus.packet, 0);
    go = 0;
    @(negedge clk);
    nreset = 1;
    run(3, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
